// File: rtl/cpu_phase_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_phase_sequencer: PC owner and multi-cycle instruction-phase FSM.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_phase_sequencer #(
  parameter int unsigned FETCH_WAIT = 1,
  parameter int unsigned MEM_WAIT   = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        fast_clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        halt_req,
  input  logic        dec_is_mem,
  input  logic        dec_mem_write,
  input  logic        dec_reg_write,
  input  logic        dec_halt,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic        instr_en,
  output logic        mem_we,
  output logic        regwr_en,
  output logic        carry_en,
  output logic [2:0]  state,
  output logic        busy,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } phaseState_e;

  localparam logic [3:0] c_FETCH_WAIT = 4'(FETCH_WAIT);
  localparam logic [3:0] c_MEM_WAIT   = 4'(MEM_WAIT);

  phaseState_e r_state;
  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic [3:0]  r_waitCnt;
  logic        r_stepMode;
  logic        r_isMem;
  logic        r_memWrite;
  logic        r_regWrite;
  logic        r_misalignErr;
  logic        r_instrEn;
  logic        r_memWe;
  logic        r_regwrEn;
  logic        r_carryEn;

  // Enables are registered alongside the transition into the state they belong to.
  always_ff @(posedge fast_clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_retired     <= 32'd0;
      r_waitCnt     <= 4'd0;
      r_stepMode    <= 1'b0;
      r_isMem       <= 1'b0;
      r_memWrite    <= 1'b0;
      r_regWrite    <= 1'b0;
      r_misalignErr <= 1'b0;
      r_instrEn     <= 1'b0;
      r_memWe       <= 1'b0;
      r_regwrEn     <= 1'b0;
      r_carryEn     <= 1'b0;
    end else begin
      r_instrEn <= 1'b0;
      r_memWe   <= 1'b0;
      r_regwrEn <= 1'b0;
      r_carryEn <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!halt_req && (run || step)) begin
            r_state    <= S_FETCH;
            r_stepMode <= !run;
            r_waitCnt  <= 4'd0;
            r_instrEn  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (r_waitCnt == c_FETCH_WAIT) begin
            r_state   <= S_DECODE;
            r_waitCnt <= 4'd0;
          end else begin
            r_waitCnt <= r_waitCnt + 4'd1;
            r_instrEn <= 1'b1;
          end
        end
        S_DECODE: begin
          r_isMem    <= dec_is_mem;
          r_memWrite <= dec_mem_write;
          r_regWrite <= dec_reg_write;
          r_state    <= dec_halt ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          r_waitCnt <= 4'd0;
          if (r_isMem) begin
            r_state <= S_MEM;
            r_memWe <= r_memWrite;
          end else begin
            r_state   <= S_WB;
            r_regwrEn <= r_regWrite;
            r_carryEn <= 1'b1;
          end
        end
        S_MEM: begin
          if (r_waitCnt == c_MEM_WAIT) begin
            r_state   <= S_WB;
            r_waitCnt <= 4'd0;
            r_regwrEn <= r_regWrite;
            r_carryEn <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 4'd1;
          end
        end
        S_WB: begin
          if (next_pc[1:0] != 2'b00) begin
            r_misalignErr <= 1'b1;
            r_state       <= S_HALT;
          end else begin
            r_pc      <= next_pc;
            r_retired <= r_retired + 32'd1;
            if (halt_req || r_stepMode || !run) begin
              r_state    <= S_IDLE;
              r_stepMode <= 1'b0;
            end else begin
              r_state   <= S_FETCH;
              r_waitCnt <= 4'd0;
              r_instrEn <= 1'b1;
            end
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc           = r_pc;
  assign retired      = r_retired;
  assign state        = r_state;
  assign instr_en     = r_instrEn;
  assign mem_we       = r_memWe;
  assign regwr_en     = r_regwrEn;
  assign carry_en     = r_carryEn;
  assign misalign_err = r_misalignErr;
  assign busy         = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted       = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_cpu_phase_sequencer.sv
`default_nettype none
// Directed bench for cpu_phase_sequencer with FETCH_WAIT=1, MEM_WAIT=2.
module tb_cpu_phase_sequencer;

  logic        fast_clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        halt_req = 1'b0;
  logic        dec_is_mem = 1'b0;
  logic        dec_mem_write = 1'b0;
  logic        dec_reg_write = 1'b0;
  logic        dec_halt = 1'b0;
  logic [31:0] next_pc = 32'd0;
  logic [31:0] pc;
  logic        instr_en;
  logic        mem_we;
  logic        regwr_en;
  logic        carry_en;
  logic [2:0]  state;
  logic        busy;
  logic        halted;
  logic        misalign_err;
  logic [31:0] retired;

  int nAsserts = 0;
  int nFails   = 0;

  cpu_phase_sequencer #(
    .FETCH_WAIT(1),
    .MEM_WAIT(2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .fast_clk(fast_clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
    .dec_is_mem(dec_is_mem), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_halt(dec_halt), .next_pc(next_pc),
    .pc(pc), .instr_en(instr_en), .mem_we(mem_we), .regwr_en(regwr_en),
    .carry_en(carry_en), .state(state), .busy(busy), .halted(halted),
    .misalign_err(misalign_err), .retired(retired)
  );

  always #5 fast_clk = ~fast_clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge fast_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] expState[8];
    logic       expWe[8];
    int         weCount;

    // Reset
    tick(2);
    checkValue("rst_state", {29'd0, state}, 32'd0);
    checkValue("rst_pc", pc, 32'd0);
    checkValue("rst_retired", retired, 32'd0);
    checkValue("rst_enables", {28'd0, instr_en, mem_we, regwr_en, carry_en}, 32'd0);
    checkValue("rst_err", {31'd0, misalign_err}, 32'd0);

    // ALU instruction, continuous run
    rst = 1'b1; run = 1'b1; dec_reg_write = 1'b1; next_pc = 32'd4;
    expState = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd0, 3'd0};
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkValue($sformatf("alu_state_%0d", i), {29'd0, state}, {29'd0, expState[i]});
      checkValue($sformatf("alu_instr_en_%0d", i), {31'd0, instr_en}, {31'd0, (i < 2)});
      checkValue($sformatf("alu_regwr_%0d", i), {31'd0, regwr_en}, {31'd0, (i == 4)});
      checkValue($sformatf("alu_carry_%0d", i), {31'd0, carry_en}, {31'd0, (i == 4)});
    end
    checkValue("alu_busy", {31'd0, busy}, 32'd1);
    tick(1);
    checkValue("alu1_pc", pc, 32'd4);
    checkValue("alu1_retired", retired, 32'd1);
    checkValue("alu1_state", {29'd0, state}, 32'd1);
    next_pc = 32'd8;
    tick(5);
    checkValue("alu2_pc", pc, 32'd8);
    checkValue("alu2_retired", retired, 32'd2);
    checkValue("alu2_state", {29'd0, state}, 32'd1);

    // Store: 3 MEM cycles, one write strobe, 8-cycle period
    dec_is_mem = 1'b1; dec_mem_write = 1'b1; dec_reg_write = 1'b0; next_pc = 32'd12;
    expState = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
    expWe    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    weCount = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (mem_we) weCount++;
      checkValue($sformatf("st_state_%0d", i), {29'd0, state}, {29'd0, expState[i]});
      checkValue($sformatf("st_mem_we_%0d", i), {31'd0, mem_we}, {31'd0, expWe[i]});
      checkValue($sformatf("st_regwr_%0d", i), {31'd0, regwr_en}, 32'd0);
    end
    checkValue("st_we_count", weCount, 32'd1);
    checkValue("st_pc", pc, 32'd12);
    checkValue("st_retired", retired, 32'd3);

    // halt_req during MEM: instruction completes, then IDLE
    next_pc = 32'd16;
    tick(4);
    checkValue("hr_in_mem", {29'd0, state}, 32'd4);
    halt_req = 1'b1;
    expState = '{3'd4, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 7; i++) begin
      tick(1);
      checkValue($sformatf("hr_state_%0d", i), {29'd0, state}, {29'd0, expState[i]});
    end
    checkValue("hr_pc", pc, 32'd16);
    checkValue("hr_retired", retired, 32'd4);
    checkValue("hr_busy", {31'd0, busy}, 32'd0);
    halt_req = 1'b0; run = 1'b0;

    // Single step
    dec_is_mem = 1'b0; dec_mem_write = 1'b0; dec_reg_write = 1'b1; next_pc = 32'd20;
    tick(2);
    checkValue("step_idle_wait", {29'd0, state}, 32'd0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    checkValue("step_fetch", {29'd0, state}, 32'd1);
    tick(4);
    checkValue("step_wb", {29'd0, state}, 32'd5);
    checkValue("step_wb_regwr", {31'd0, regwr_en}, 32'd1);
    tick(1);
    checkValue("step_idle", {29'd0, state}, 32'd0);
    checkValue("step_retired", retired, 32'd5);
    checkValue("step_pc", pc, 32'd20);
    tick(2);
    checkValue("step_stays_idle", {29'd0, state}, 32'd0);
    next_pc = 32'd24;
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(5);
    checkValue("step2_idle", {29'd0, state}, 32'd0);
    checkValue("step2_retired", retired, 32'd6);

    // run and step together: continuous run
    next_pc = 32'd28;
    run = 1'b1; step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(5);
    checkValue("runstep_state", {29'd0, state}, 32'd1);
    checkValue("runstep_retired", retired, 32'd7);
    checkValue("runstep_pc", pc, 32'd28);

    // Misaligned next_pc traps to HALT
    next_pc = 32'h0000_0006;
    tick(5);
    checkValue("mis_state", {29'd0, state}, 32'd6);
    checkValue("mis_err", {31'd0, misalign_err}, 32'd1);
    checkValue("mis_halted", {31'd0, halted}, 32'd1);
    checkValue("mis_pc", pc, 32'd28);
    checkValue("mis_retired", retired, 32'd7);
    tick(3);
    checkValue("mis_absorbing", {29'd0, state}, 32'd6);
    rst = 1'b0;
    tick(1);
    checkValue("mis_rst_state", {29'd0, state}, 32'd0);
    checkValue("mis_rst_pc", pc, 32'd0);
    checkValue("mis_rst_err", {31'd0, misalign_err}, 32'd0);
    checkValue("mis_rst_retired", retired, 32'd0);

    // dec_halt in DECODE
    rst = 1'b1; dec_halt = 1'b1; dec_is_mem = 1'b1; dec_mem_write = 1'b1; next_pc = 32'd4;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checkValue($sformatf("dh_gates_%0d", i), {29'd0, mem_we, regwr_en, carry_en}, 32'd0);
    end
    checkValue("dh_state", {29'd0, state}, 32'd6);
    checkValue("dh_pc", pc, 32'd0);
    checkValue("dh_retired", retired, 32'd0);

    // Reset mid-FETCH after one completed instruction
    rst = 1'b0;
    tick(1);
    rst = 1'b1; dec_halt = 1'b0; dec_is_mem = 1'b0; dec_mem_write = 1'b0;
    tick(6);
    checkValue("rf_retired_pre", retired, 32'd1);
    checkValue("rf_state_pre", {29'd0, state}, 32'd1);
    rst = 1'b0;
    tick(1);
    checkValue("rf_state", {29'd0, state}, 32'd0);
    checkValue("rf_retired", retired, 32'd0);
    checkValue("rf_pc", pc, 32'd0);
    checkValue("rf_instr_en", {31'd0, instr_en}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
Multi-cycle instruction sequencer for the KGP-RISC single-issue core. Owns the program counter register and the instruction-lifecycle FSM (FETCH, DECODE, EXEC, MEM, WB). Emits one-hot phase enables that gate instruction-memory read, data-memory write, register-file write and carry-flag capture in the datapath. Supports run/step/halt control, configurable memory wait states, misaligned-PC trapping and a retired-instruction counter.

Parameters:
FETCH_WAIT, 1, extra cycles FETCH holds instr_en before DECODE (0..15)
MEM_WAIT, 2, extra cycles MEM holds mem_en before WB (0..15)
RESET_PC, 32'h0000_0000, PC value after reset; must be word aligned

Ports:
fast_clk  in  1  single clock; all state changes on rising edge
rst  in  1  synchronous reset, active-low
run  in  1  level; continuous execution while high
step  in  1  single-cycle pulse; executes exactly one instruction from IDLE
halt_req  in  1  level; stop at next instruction boundary
dec_is_mem  in  1  decoded MemWrite|MemtoReg; valid during DECODE
dec_mem_write  in  1  decoded MemWrite; valid during DECODE
dec_reg_write  in  1  decoded RegWrite; valid during DECODE
dec_halt  in  1  decoded halt opcode; valid during DECODE
next_pc  in  32  nextInstrAdr_ from datapath; valid during WB
pc  out  32  currInstrAdr to datapath
instr_en  out  1  instruction-memory read enable
mem_we  out  1  gated data-memory write strobe
regwr_en  out  1  gated register-file write enable
carry_en  out  1  carry-flag capture enable
state  out  3  FSM encoding (debug)
busy  out  1  high in any state other than IDLE/HALT
halted  out  1  high in HALT
misalign_err  out  1  sticky; set when trapped on misaligned next_pc
retired  out  32  count of completed instructions

Behaviour:
- Reset (rst=0 at edge): state=IDLE, pc=RESET_PC, all enables 0, retired=0, misalign_err=0, wait counter=0, step_mode=0, latched decode bits=0. Reset wins over every other input in any state, including mid-MEM.
- Encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; 7 unreachable, recovers to IDLE next cycle.
- IDLE: run=1 -> FETCH, step_mode=0. Else step=1 -> FETCH, step_mode=1. run has priority when both high. halt_req high in IDLE blocks both.
- FETCH: instr_en=1 every cycle; stays FETCH_WAIT+1 cycles via 4-bit counter, then DECODE.
- DECODE: 1 cycle; latches dec_is_mem, dec_mem_write, dec_reg_write. dec_halt=1 -> HALT; pc unchanged, retired unchanged.
- EXEC: 1 cycle -> MEM if latched is_mem, else WB.
- MEM: stays MEM_WAIT+1 cycles. mem_we=1 only on the first MEM cycle and only if latched mem_write, so exactly one write per store. Then WB.
- WB: 1 cycle. regwr_en=latched reg_write; carry_en=1. If next_pc[1:0]!=0: misalign_err<=1, pc unchanged, -> HALT, retired unchanged. Else pc<=next_pc, retired<=retired+1 (wraps 2^32-1 -> 0). Then -> IDLE if halt_req=1 or step_mode=1 or run=0 (step_mode cleared); else -> FETCH.
- HALT: absorbing; exit only by reset. All enables 0.
- halt_req and run are sampled only in IDLE and WB; an instruction in flight always completes.
- Latency: non-memory instruction = FETCH_WAIT+4 cycles from FETCH entry to next FETCH entry; memory instruction adds MEM_WAIT+1.
- All outputs are registered-state-derived (Moore); no combinational path from inputs to enables.

Test Plan:
- Reset then run=1, dec_is_mem=0, dec_reg_write=1, next_pc=pc+4, defaults -> FETCH 2 cycles, DECODE, EXEC, WB; pc 0->4->8, retired increments every 5 cycles, regwr_en one cycle per instruction.
- Store: dec_is_mem=1, dec_mem_write=1, MEM_WAIT=2 -> MEM lasts 3 cycles, mem_we high only the first, instruction period 8 cycles, regwr_en=0 when dec_reg_write=0.
- step pulse from IDLE with run=0 -> exactly one instruction, retired 0->1, return to IDLE; second pulse -> retired=2; run+step together -> continuous run.
- halt_req asserted during MEM -> MEM/WB complete, pc updated, retired incremented, then IDLE; no FETCH entered.
- next_pc=32'h0000_0006 in WB -> misalign_err=1, halted=1, pc keeps old value; rst=0 clears to IDLE, pc=RESET_PC.
- dec_halt=1 in DECODE -> HALT, no regwr_en/mem_we/carry_en; rst=0 asserted mid-FETCH in a later run -> next cycle IDLE, retired=0.
